// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;
  localparam int              REG_ADDR_W = 5;
  localparam logic [4:0]      ZERO_REG   = 5'd0;
  localparam logic            GRANT_A    = 1'b0;
  localparam logic            GRANT_B    = 1'b1;
endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on alloc, cleared on retire.
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid_i,
  input  logic [REG_ADDR_W-1:0] alloc_addr_i,
  input  logic                  retire_valid_i,
  input  logic [REG_ADDR_W-1:0] retire_addr_i,
  output logic [NUM_REGS-1:0]   busy_o
);
  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Set is applied after clear so a producer issued on the retire edge keeps the bit.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (retire_valid_i && retire_addr_i == REG_ADDR_W'(r)) busy_d[r] = 1'b0;
      if (alloc_valid_i && alloc_addr_i == REG_ADDR_W'(r))   busy_d[r] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_o = busy_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port between ALU (A) and long-latency (B)
// writeback, with a registered write port and a RAW scoreboard.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int bit_size = 32,
  parameter int NUM_REGS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  input  logic [REG_ADDR_W-1:0] a_addr,
  input  logic [bit_size-1:0]   a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [REG_ADDR_W-1:0] b_addr,
  input  logic [bit_size-1:0]   b_data,
  output logic                  b_ready,
  input  logic                  alloc_valid,
  input  logic [REG_ADDR_W-1:0] alloc_addr,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] Write_addr,
  output logic [bit_size-1:0]   Write_data
);
  logic                  last_grant_q, last_grant_d;
  logic                  coll_q, coll_d;
  logic                  gnt_a, gnt_b, gnt_any;
  logic [REG_ADDR_W-1:0] gnt_addr;
  logic [bit_size-1:0]   gnt_data;
  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
  logic [bit_size-1:0]   wdata_q, wdata_d;

  // coll_q remembers a same-address B grant so the younger A write follows immediately.
  always_comb begin
    gnt_a        = 1'b0;
    gnt_b        = 1'b0;
    coll_d       = 1'b0;
    if (!rst) begin
      if (a_valid && b_valid) begin
        if (coll_q)                        gnt_a = 1'b1;
        else if (a_addr == b_addr) begin   gnt_b = 1'b1; coll_d = 1'b1; end
        else if (last_grant_q == GRANT_B)  gnt_a = 1'b1;
        else                               gnt_b = 1'b1;
      end else begin
        gnt_a = a_valid;
        gnt_b = b_valid;
      end
    end
    gnt_any      = gnt_a | gnt_b;
    last_grant_d = gnt_a ? GRANT_A : (gnt_b ? GRANT_B : last_grant_q);
    gnt_addr     = gnt_b ? b_addr : a_addr;
    gnt_data     = gnt_b ? b_data : a_data;
  end

  // Writes to r0 are consumed but never reach the port; address/data hold while idle.
  always_comb begin
    we_d    = gnt_any && (gnt_addr != ZERO_REG);
    waddr_d = we_d ? gnt_addr : waddr_q;
    wdata_d = we_d ? gnt_data : wdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= GRANT_B;
      coll_q       <= 1'b0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      coll_q       <= coll_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign a_ready    = gnt_a;
  assign b_ready    = gnt_b;
  assign RegWrite   = we_q;
  assign Write_addr = waddr_q;
  assign Write_data = wdata_q;

  wb_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
    .clk           (clk),
    .rst           (rst),
    .alloc_valid_i (alloc_valid),
    .alloc_addr_i  (alloc_addr),
    .retire_valid_i(we_q),
    .retire_addr_i (waddr_q),
    .busy_o        (busy)
  );
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters.
  - Port A: single-cycle ALU results.
  - Port B: long-latency results (load / mult-div).
- Arbitrates round-robin and registers the winning write onto the regfile write port (RegWrite / Write_addr / Write_data).
- Keeps a per-register pending-write scoreboard so decode can stall on RAW hazards.
- Sits between the execute/memory stages and the regfile.

Parameters:
- bit_size, 32, data width of writeback values and regfile entries.
- NUM_REGS, 32, number of architectural registers; addr width fixed at 5.

Ports:
- clk  input  1  clock, posedge.
- rst  input  1  reset, asynchronous, active-high.
- a_valid  input  1  port A write request.
- a_addr  input  5  port A destination register.
- a_data  input  bit_size  port A write data.
- a_ready  output  1  port A accepted this cycle.
- b_valid  input  1  port B write request.
- b_addr  input  5  port B destination register.
- b_data  input  bit_size  port B write data.
- b_ready  output  1  port B accepted this cycle.
- alloc_valid  input  1  decode issued an instruction with a destination register.
- alloc_addr  input  5  destination being allocated.
- busy  output  NUM_REGS  scoreboard; bit r=1 means a write to r is outstanding.
- RegWrite  output  1  regfile write enable.
- Write_addr  output  5  regfile write address.
- Write_data  output  bit_size  regfile write data.

Behaviour:
- **Reset.** Asynchronous, active-high; clk and rst as already decided. Reset clears:
  - RegWrite=0, Write_addr=0, Write_data=0;
  - busy=0;
  - last_grant=B, so A wins the first contested cycle.
- **Handshake.** valid/ready.
  - A requester holds valid, addr and data stable until ready=1.
  - Transfer occurs on a clock edge where valid&&ready.
  - ready is combinational from the valid inputs, the addresses and last_grant.
  - At most one of a_ready / b_ready is 1 per cycle.
- **Arbitration.**
  - Only one valid: that port is granted.
  - Both valid, different addr: grant the port not in last_grant; last_grant updates on every grant.
  - Both valid, same addr: grant B this cycle and A in the next cycle, regardless of last_grant. A's (younger) value lands last and is the final regfile content. last_grant is set to A after the A grant.
- **Latency.** Granted write appears on RegWrite/Write_addr/Write_data exactly 1 cycle after the accepting edge.
  - RegWrite deasserts the cycle after a cycle with no grant.
  - Write_addr and Write_data hold their last value while RegWrite=0.
- **Register 0.**
  - A request to addr 0 is accepted normally (ready asserted, arbitration consumed).
  - It drives RegWrite=0 on the output.
  - alloc to addr 0 never sets busy[0]; busy[0] is constant 0.
- **Scoreboard.**
  - On a clock edge with alloc_valid, busy[alloc_addr] is set to 1.
  - On the edge where a write to r is presented (RegWrite=1, Write_addr=r), busy[r] is cleared.
  - Set and clear of the same r on the same edge: set wins; busy[r] stays 1 because a new producer was issued.
  - Two allocs to the same r before retirement are not counted; the first retire clears the bit. Decode must stall on busy before re-allocating.
- **Reset mid-operation.** In-flight granted writes are discarded: RegWrite=0 immediately, busy cleared, requests pending at reset are not accepted until rst deasserts.
- **Structure.** No FIFO; backpressure only via ready. No combinational path from the data inputs to outputs other than ready.

Decomposition:
- Shared package holds:
  - REG_ADDR_W=5;
  - ZERO_REG=5'd0;
  - grant encoding constants GRANT_A=1'b0, GRANT_B=1'b1.
- One sub-module, wb_scoreboard: busy vector, alloc/retire inputs, set-wins rule.
- Arbiter and output register stay in the top.

Test Plan:
- **Idle after reset.** Assert rst mid-cycle with no requests. Then RegWrite=0, busy=0, a_ready=b_ready=0 while rst is held.
- **Single A.** a_valid=1, a_addr=5, a_data=0xDEADBEEF. a_ready=1 the same cycle; next cycle RegWrite=1, Write_addr=5, Write_data=0xDEADBEEF.
- **Contention, different addresses.** a(addr 3)+b(addr 7) held valid for 4 cycles with new data each accept. Grants alternate A,B,A,B starting with A; RegWrite stream is addr 3,7,3,7.
- **Same-address collision.** a(addr 9, 0x1111)+b(addr 9, 0x2222). B is granted first, then A. Write_data sequence 0x2222 then 0x1111; final regfile[9]=0x1111.
- **Zero register.** a_valid with addr 0, data 0xFFFFFFFF. a_ready=1, RegWrite stays 0 next cycle. alloc_addr=0 leaves busy[0]=0.
- **Scoreboard.**
  - alloc addr 12: busy[12]=1 next cycle.
  - B write to 12: busy[12]=0 on the edge where RegWrite presents addr 12.
  - alloc 12 on that same edge: busy[12] stays 1.
